// File: rtl/sa_ram_pkg.sv
// Shared helpers for the single-port-array RAM models: address width,
// power-down decode and even parity over a word of up to 1024 bits.
package sa_ram_pkg;

    function automatic int sa_aw(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic logic sa_pd_active(input logic [31:0] pd);
        return |pd;
    endfunction

    function automatic logic sa_parity(input logic [1023:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/sa_ram_rwsthp_param_if.sv
// Read/write bus of the RAM: read port, write port, bypass, power-down
// and status outputs. master drives requests, slave returns data/status.
interface sa_ram_rwsthp_param_if #(
    parameter int AW    = 6,
    parameter int WIDTH = 168
);
    logic [AW-1:0]    ra;
    logic             re;
    logic             ore;
    logic [WIDTH-1:0] dout;
    logic             dout_vld;
    logic [AW-1:0]    wa;
    logic             we;
    logic [WIDTH-1:0] di;
    logic             byp_sel;
    logic [WIDTH-1:0] dbyp;
    logic [31:0]      pwrbus_ram_pd;
    logic             parity_err;

    modport master (
        output ra, re, ore, wa, we, di, byp_sel, dbyp, pwrbus_ram_pd,
        input  dout, dout_vld, parity_err
    );

    modport slave (
        input  ra, re, ore, wa, we, di, byp_sel, dbyp, pwrbus_ram_pd,
        output dout, dout_vld, parity_err
    );
endinterface

// File: rtl/sa_ram_rd_pipe.sv
// Two-stage read pipe: stage 1 captures ra_d/pending and same-cycle write
// data, stage 2 loads dout (array, forward or bypass) and dout_vld.
// Ports: clk, rstn, bus (slave), mem_rdata (array word at ra_d), ra_d.
// SA_RAM_PARITY_EN: word carries an even-parity MSB, checked on load.
module sa_ram_rd_pipe
    import sa_ram_pkg::*;
#(
    parameter int DEPTH = 60,
    parameter int WIDTH = 168,
    parameter int AW    = 6,
    parameter int SW    = WIDTH
) (
    input  logic                   clk,
    input  logic                   rstn,
    sa_ram_rwsthp_param_if.slave   bus,
    input  logic [SW-1:0]          mem_rdata,
    output logic [AW-1:0]          ra_d
);

    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

    logic [AW-1:0]    ra_d_q, ra_d_d;
    logic             pend_q, pend_d;
    logic [SW-1:0]    fwd_q, fwd_d;
    logic             fwd_vld_q, fwd_vld_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             vld_q, vld_d;
    logic             pd;
    logic             fwd_hit;
    logic [SW-1:0]    wword;
    logic [SW-1:0]    sel;

    // Forwarding only mirrors writes that really land in the array.
    always_comb begin
        pd      = sa_pd_active(bus.pwrbus_ram_pd);
        fwd_hit = bus.re && bus.we && !pd && (bus.ra == bus.wa)
                  && ({1'b0, bus.wa} < DEPTH_W);
        wword   = '0;
        wword[WIDTH-1:0] = bus.di;
`ifdef SA_RAM_PARITY_EN
        wword[SW-1] = sa_parity(1024'(bus.di));
`endif
        sel = fwd_vld_q ? fwd_q : mem_rdata;
    end

    always_comb begin
        ra_d_d    = ra_d_q;
        pend_d    = pend_q;
        fwd_d     = fwd_q;
        fwd_vld_d = fwd_vld_q;
        dout_d    = dout_q;
        vld_d     = vld_q;
        // A new read issued alongside ore stays pending.
        if (bus.ore && !pd) begin
            dout_d = bus.byp_sel ? bus.dbyp : sel[WIDTH-1:0];
            vld_d  = pend_q | bus.byp_sel;
            pend_d = 1'b0;
        end
        if (bus.re) begin
            ra_d_d    = bus.ra;
            pend_d    = 1'b1;
            fwd_vld_d = fwd_hit;
            if (fwd_hit) begin
                fwd_d = wword;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ra_d_q    <= '0;
            pend_q    <= 1'b0;
            fwd_q     <= '0;
            fwd_vld_q <= 1'b0;
            dout_q    <= '0;
            vld_q     <= 1'b0;
        end else begin
            ra_d_q    <= ra_d_d;
            pend_q    <= pend_d;
            fwd_q     <= fwd_d;
            fwd_vld_q <= fwd_vld_d;
            dout_q    <= dout_d;
            vld_q     <= vld_d;
        end
    end

`ifdef SA_RAM_PARITY_EN
    logic perr_q, perr_d;

    // Only real array/forward data of a pending read is checked.
    always_comb begin
        perr_d = perr_q;
        if (bus.ore && !pd && !bus.byp_sel && pend_q
            && (sel[SW-1] != sa_parity(1024'(sel[WIDTH-1:0])))) begin
            perr_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            perr_q <= 1'b0;
        end else begin
            perr_q <= perr_d;
        end
    end

    assign bus.parity_err = perr_q;
`else
    assign bus.parity_err = 1'b0;
`endif

    assign ra_d         = ra_d_q;
    assign bus.dout     = dout_q;
    assign bus.dout_vld = vld_q;

endmodule

// File: rtl/sa_ram_rwsthp_param.sv
// Single-clock RAM, one write port and a 2-cycle registered read port with
// bypass, power-down and optional parity (macro SA_RAM_PARITY_EN).
// Ports: clk, rstn, ra/re, ore, dout/dout_vld, wa/we/di, byp_sel/dbyp,
// pwrbus_ram_pd, parity_err.
module sa_ram_rwsthp_param
    import sa_ram_pkg::*;
#(
    parameter int DEPTH = 60,
    parameter int WIDTH = 168,
    parameter int AW    = sa_aw(DEPTH)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [AW-1:0]    ra,
    input  logic             re,
    input  logic             ore,
    output logic [WIDTH-1:0] dout,
    output logic             dout_vld,
    input  logic [AW-1:0]    wa,
    input  logic             we,
    input  logic [WIDTH-1:0] di,
    input  logic             byp_sel,
    input  logic [WIDTH-1:0] dbyp,
    input  logic [31:0]      pwrbus_ram_pd,
    output logic             parity_err
);

`ifdef SA_RAM_PARITY_EN
    localparam int SW = WIDTH + 1;
`else
    localparam int SW = WIDTH;
`endif

    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

    sa_ram_rwsthp_param_if #(.AW(AW), .WIDTH(WIDTH)) bus ();

    assign bus.ra            = ra;
    assign bus.re            = re;
    assign bus.ore           = ore;
    assign bus.wa            = wa;
    assign bus.we            = we;
    assign bus.di            = di;
    assign bus.byp_sel       = byp_sel;
    assign bus.dbyp          = dbyp;
    assign bus.pwrbus_ram_pd = pwrbus_ram_pd;
    assign dout              = bus.dout;
    assign dout_vld          = bus.dout_vld;
    assign parity_err        = bus.parity_err;

    logic [SW-1:0] mem_q [DEPTH];
    logic [SW-1:0] wword;
    logic [SW-1:0] mem_rdata;
    logic [AW-1:0] ra_d;
    logic          wen;

    always_comb begin
        wen   = we && !sa_pd_active(pwrbus_ram_pd)
                && ({1'b0, wa} < DEPTH_W);
        wword = '0;
        wword[WIDTH-1:0] = di;
`ifdef SA_RAM_PARITY_EN
        wword[SW-1] = sa_parity(1024'(di));
`endif
    end

    // Array has no reset; contents are undefined until written.
    always_ff @(posedge clk) begin
        if (wen) begin
            mem_q[wa] <= wword;
        end
    end

    always_comb begin
        mem_rdata = '0;
        if ({1'b0, ra_d} < DEPTH_W) begin
            mem_rdata = mem_q[ra_d];
        end
    end

    sa_ram_rd_pipe #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH),
        .AW    (AW),
        .SW    (SW)
    ) u_rd_pipe (
        .clk       (clk),
        .rstn      (rstn),
        .bus       (bus.slave),
        .mem_rdata (mem_rdata),
        .ra_d      (ra_d)
    );

endmodule

// File: tb/tb_sa_ram_rwsthp_param.sv
// Directed self-checking bench for sa_ram_rwsthp_param (DEPTH 60,
// WIDTH 168); parity scenario built only with SA_RAM_PARITY_EN.
module tb_sa_ram_rwsthp_param;

    localparam int DEPTH = 60;
    localparam int WIDTH = 168;
    localparam int AW    = 6;

    logic clk;
    logic rstn;
    int   n_cmp;
    int   n_bad;

    sa_ram_rwsthp_param_if #(.AW(AW), .WIDTH(WIDTH)) tb_if ();

    sa_ram_rwsthp_param #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH),
        .AW    (AW)
    ) dut (
        .clk           (clk),
        .rstn          (rstn),
        .ra            (tb_if.ra),
        .re            (tb_if.re),
        .ore           (tb_if.ore),
        .dout          (tb_if.dout),
        .dout_vld      (tb_if.dout_vld),
        .wa            (tb_if.wa),
        .we            (tb_if.we),
        .di            (tb_if.di),
        .byp_sel       (tb_if.byp_sel),
        .dbyp          (tb_if.dbyp),
        .pwrbus_ram_pd (tb_if.pwrbus_ram_pd),
        .parity_err    (tb_if.parity_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        tb_if.ra = '0;
        tb_if.re = 1'b0;
        tb_if.ore = 1'b0;
        tb_if.wa = '0;
        tb_if.we = 1'b0;
        tb_if.di = '0;
        tb_if.byp_sel = 1'b0;
        tb_if.dbyp = '0;
        tb_if.pwrbus_ram_pd = '0;
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
        tb_if.we = 1'b1;
        tb_if.wa = a;
        tb_if.di = d;
        cyc();
        tb_if.we = 1'b0;
    endtask

    task automatic rd(input logic [AW-1:0] a);
        tb_if.re = 1'b1;
        tb_if.ra = a;
        cyc();
        tb_if.re = 1'b0;
        tb_if.ore = 1'b1;
        cyc();
        tb_if.ore = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        rstn = 1'b0;
        cyc();
        cyc();
        n_cmp++;
        if (tb_if.dout !== '0) begin
            n_bad++;
            $display("FAIL reset_dout got %h want 0", tb_if.dout);
        end
        n_cmp++;
        if (tb_if.dout_vld !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_vld got %b want 0", tb_if.dout_vld);
        end
        n_cmp++;
        if (tb_if.parity_err !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_perr got %b want 0", tb_if.parity_err);
        end
        rstn = 1'b1;
        cyc();
    endtask

    task automatic test_write_read();
        wr(6'd3, 168'hA5);
        wr(6'd0, 168'h100);
        wr(6'd59, 168'h3B3B);
        tb_if.re = 1'b1;
        tb_if.ra = 6'd3;
        cyc();
        tb_if.re = 1'b0;
        tb_if.ore = 1'b1;
        n_cmp++;
        if (tb_if.dout_vld !== 1'b0) begin
            n_bad++;
            $display("FAIL lat_vld_early got %b want 0", tb_if.dout_vld);
        end
        cyc();
        tb_if.ore = 1'b0;
        n_cmp++;
        if (tb_if.dout !== 168'hA5) begin
            n_bad++;
            $display("FAIL rd3_dout got %h want a5", tb_if.dout);
        end
        n_cmp++;
        if (tb_if.dout_vld !== 1'b1) begin
            n_bad++;
            $display("FAIL rd3_vld got %b want 1", tb_if.dout_vld);
        end
        rd(6'd0);
        n_cmp++;
        if (tb_if.dout !== 168'h100) begin
            n_bad++;
            $display("FAIL rd0 got %h want 100", tb_if.dout);
        end
        rd(6'd59);
        n_cmp++;
        if (tb_if.dout !== 168'h3B3B) begin
            n_bad++;
            $display("FAIL rd59 got %h want 3b3b", tb_if.dout);
        end
    endtask

    task automatic test_collision();
        wr(6'd7, 168'h55);
        tb_if.we = 1'b1;
        tb_if.wa = 6'd7;
        tb_if.di = 168'h1234;
        tb_if.re = 1'b1;
        tb_if.ra = 6'd7;
        cyc();
        tb_if.we = 1'b0;
        tb_if.re = 1'b0;
        tb_if.ore = 1'b1;
        cyc();
        tb_if.ore = 1'b0;
        n_cmp++;
        if (tb_if.dout !== 168'h1234) begin
            n_bad++;
            $display("FAIL collide got %h want 1234", tb_if.dout);
        end
    endtask

    task automatic test_bypass();
        tb_if.byp_sel = 1'b1;
        tb_if.dbyp = 168'hFF;
        tb_if.ore = 1'b1;
        cyc();
        tb_if.byp_sel = 1'b0;
        tb_if.dbyp = '0;
        n_cmp++;
        if (tb_if.dout !== 168'hFF) begin
            n_bad++;
            $display("FAIL byp_dout got %h want ff", tb_if.dout);
        end
        n_cmp++;
        if (tb_if.dout_vld !== 1'b1) begin
            n_bad++;
            $display("FAIL byp_vld got %b want 1", tb_if.dout_vld);
        end
        cyc();
        tb_if.ore = 1'b0;
        n_cmp++;
        if (tb_if.dout_vld !== 1'b0) begin
            n_bad++;
            $display("FAIL nopend_vld got %b want 0", tb_if.dout_vld);
        end
    endtask

    task automatic test_out_of_range();
        rd(6'd60);
        n_cmp++;
        if (tb_if.dout !== '0) begin
            n_bad++;
            $display("FAIL oor_dout got %h want 0", tb_if.dout);
        end
        n_cmp++;
        if (tb_if.dout_vld !== 1'b1) begin
            n_bad++;
            $display("FAIL oor_vld got %b want 1", tb_if.dout_vld);
        end
        wr(6'd60, {WIDTH{1'b1}});
        rd(6'd59);
        n_cmp++;
        if (tb_if.dout !== 168'h3B3B) begin
            n_bad++;
            $display("FAIL oor_wr59 got %h want 3b3b", tb_if.dout);
        end
        rd(6'd0);
        n_cmp++;
        if (tb_if.dout !== 168'h100) begin
            n_bad++;
            $display("FAIL oor_wr0 got %h want 100", tb_if.dout);
        end
    endtask

    task automatic test_power_down();
        wr(6'd5, 168'h0505);
        rd(6'd3);
        n_cmp++;
        if (tb_if.dout !== 168'hA5) begin
            n_bad++;
            $display("FAIL pd_pre got %h want a5", tb_if.dout);
        end
        tb_if.pwrbus_ram_pd = 32'd1;
        tb_if.we = 1'b1;
        tb_if.wa = 6'd5;
        tb_if.di = 168'hBEEF;
        tb_if.re = 1'b1;
        tb_if.ra = 6'd5;
        tb_if.ore = 1'b1;
        cyc();
        tb_if.pwrbus_ram_pd = '0;
        tb_if.we = 1'b0;
        tb_if.re = 1'b0;
        n_cmp++;
        if (tb_if.dout !== 168'hA5) begin
            n_bad++;
            $display("FAIL pd_hold got %h want a5", tb_if.dout);
        end
        n_cmp++;
        if (tb_if.dout_vld !== 1'b1) begin
            n_bad++;
            $display("FAIL pd_vld got %b want 1", tb_if.dout_vld);
        end
        cyc();
        tb_if.ore = 1'b0;
        n_cmp++;
        if (tb_if.dout !== 168'h0505) begin
            n_bad++;
            $display("FAIL pd_m5 got %h want 0505", tb_if.dout);
        end
        n_cmp++;
        if (tb_if.dout_vld !== 1'b1) begin
            n_bad++;
            $display("FAIL pd_pend got %b want 1", tb_if.dout_vld);
        end
    endtask

    task automatic test_reset_mid_read();
        tb_if.re = 1'b1;
        tb_if.ra = 6'd3;
        cyc();
        tb_if.re = 1'b0;
        rstn = 1'b0;
        #2;
        n_cmp++;
        if (tb_if.dout !== '0) begin
            n_bad++;
            $display("FAIL rstmid_dout got %h want 0", tb_if.dout);
        end
        n_cmp++;
        if (tb_if.dout_vld !== 1'b0) begin
            n_bad++;
            $display("FAIL rstmid_vld got %b want 0", tb_if.dout_vld);
        end
        rstn = 1'b1;
        tb_if.ore = 1'b1;
        cyc();
        tb_if.ore = 1'b0;
        n_cmp++;
        if (tb_if.dout_vld !== 1'b0) begin
            n_bad++;
            $display("FAIL rstmid_ore got %b want 0", tb_if.dout_vld);
        end
    endtask

    task automatic test_back_to_back();
        tb_if.re = 1'b1;
        tb_if.ra = 6'd0;
        cyc();
        tb_if.ra = 6'd3;
        tb_if.ore = 1'b1;
        cyc();
        tb_if.re = 1'b0;
        n_cmp++;
        if (tb_if.dout !== 168'h100) begin
            n_bad++;
            $display("FAIL b2b_0 got %h want 100", tb_if.dout);
        end
        cyc();
        tb_if.ore = 1'b0;
        n_cmp++;
        if (tb_if.dout !== 168'hA5 || tb_if.dout_vld !== 1'b1) begin
            n_bad++;
            $display("FAIL b2b_3 got %h/%b want a5/1",
                     tb_if.dout, tb_if.dout_vld);
        end
    endtask

    task automatic test_read_old();
        wr(6'd10, 168'h1010);
        tb_if.re = 1'b1;
        tb_if.ra = 6'd10;
        cyc();
        tb_if.re = 1'b0;
        tb_if.ore = 1'b1;
        tb_if.we = 1'b1;
        tb_if.wa = 6'd10;
        tb_if.di = 168'h9999;
        cyc();
        tb_if.ore = 1'b0;
        tb_if.we = 1'b0;
        n_cmp++;
        if (tb_if.dout !== 168'h1010) begin
            n_bad++;
            $display("FAIL rdold got %h want 1010", tb_if.dout);
        end
        rd(6'd10);
        n_cmp++;
        if (tb_if.dout !== 168'h9999) begin
            n_bad++;
            $display("FAIL rdnew got %h want 9999", tb_if.dout);
        end
    endtask

`ifdef SA_RAM_PARITY_EN
    task automatic test_parity();
        wr(6'd2, 168'h22);
        rd(6'd2);
        n_cmp++;
        if (tb_if.parity_err !== 1'b0) begin
            n_bad++;
            $display("FAIL par_clean got %b want 0", tb_if.parity_err);
        end
        dut.mem_q[2][WIDTH] = ~dut.mem_q[2][WIDTH];
        rd(6'd2);
        n_cmp++;
        if (tb_if.parity_err !== 1'b1) begin
            n_bad++;
            $display("FAIL par_set got %b want 1", tb_if.parity_err);
        end
        rd(6'd3);
        n_cmp++;
        if (tb_if.parity_err !== 1'b1) begin
            n_bad++;
            $display("FAIL par_sticky got %b want 1", tb_if.parity_err);
        end
        rstn = 1'b0;
        #2;
        n_cmp++;
        if (tb_if.parity_err !== 1'b0) begin
            n_bad++;
            $display("FAIL par_rst got %b want 0", tb_if.parity_err);
        end
        rstn = 1'b1;
        cyc();
    endtask
`endif

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rstn = 1'b0;
        idle();
        test_reset();
        test_write_read();
        test_collision();
        test_bypass();
        test_out_of_range();
        test_power_down();
        test_reset_mid_read();
        test_back_to_back();
        test_read_old();
`ifdef SA_RAM_PARITY_EN
        test_parity();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
